hazard_info_pipe: RTL

// - Producer side of the stall/forward hazard interface: decodes D-stage instruction into rs/rt, Tuse, dest reg, RegWrite, Tnew.
// - Carries dest/RegWrite/Tnew/rs/rt through E(_2), M(_3), W(_4) pipeline registers, aging Tnew each cycle.
// - Consumes `stall` from the hazard unit: holds nothing itself, but injects a bubble into E when stalled.
// - Sits beside the datapath pipeline registers; outputs wire directly into the hazard unit's inputs.

---
 rtl/hazard_info_pipe_pkg.sv | 36 +++
 rtl/hazard_info_pipe_decode.sv | 103 ++++++++++
 rtl/hazard_info_pipe.sv | 101 ++++++++++
 3 files changed

// File: rtl/hazard_info_pipe_pkg.sv
// Shared opcode/funct constants and the per-stage hazard info bundle.
// Imported by the decoder and the pipeline-register top.
package hazard_info_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Tuse reported for an operand the instruction never reads
    localparam logic [1:0] TUSE_NONE = 2'd3;
    // Link register written by jal
    localparam logic [4:0] RA_REG    = 5'd31;

    typedef struct packed {
        logic [4:0] wa;
        logic       we;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } stage_info_t;

    // One cycle of aging; saturates at 0 so Tnew never wraps to 3
    function automatic logic [1:0] tnew_age(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_info_pipe_decode.sv
// hazard_info_decode: combinational D-stage decode of dest reg, write
// enable, Tnew at E and operand Tuse. Ports: instr_i/valid_i in; wa/we/tnew/Tuse out.
module hazard_info_decode
    import hazard_info_pipe_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    output logic [4:0]  wa_o,
    output logic        we_o,
    output logic [1:0]  tnew_o,
    output logic [1:0]  rs_tuse_o,
    output logic [1:0]  rt_tuse_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_r;
    logic       is_alu;
    logic       is_jr;
    logic       is_ori;
    logic       is_lui;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_jal;
    logic       wr;
    logic [4:0] wa;
    logic       unused_shamt;

    assign op = instr_i[31:26];
    assign fn = instr_i[5:0];
    assign rt = instr_i[20:16];
    assign rd = instr_i[15:11];
    assign unused_shamt = ^instr_i[10:6];

    assign is_r   = valid_i && (op == OP_RTYPE);
    assign is_alu = is_r && ((fn == FN_ADDU) || (fn == FN_SUBU));
    assign is_jr  = is_r && (fn == FN_JR);
    assign is_ori = valid_i && (op == OP_ORI);
    assign is_lui = valid_i && (op == OP_LUI);
    assign is_lw  = valid_i && (op == OP_LW);
    assign is_sw  = valid_i && (op == OP_SW);
    assign is_beq = valid_i && (op == OP_BEQ);
    assign is_jal = valid_i && (op == OP_JAL);

    always_comb begin
        wr        = 1'b0;
        wa        = 5'd0;
        tnew_o    = 2'd0;
        rs_tuse_o = TUSE_NONE;
        rt_tuse_o = TUSE_NONE;
        unique case (1'b1)
            is_alu: begin
                wr        = 1'b1;
                wa        = rd;
                tnew_o    = 2'd1;
                rs_tuse_o = 2'd1;
                rt_tuse_o = 2'd1;
            end
            is_ori: begin
                wr        = 1'b1;
                wa        = rt;
                tnew_o    = 2'd1;
                rs_tuse_o = 2'd1;
            end
            is_lui: begin
                wr     = 1'b1;
                wa     = rt;
                tnew_o = 2'd1;
            end
            is_lw: begin
                wr        = 1'b1;
                wa        = rt;
                tnew_o    = 2'd2;
                rs_tuse_o = 2'd1;
            end
            is_sw: begin
                rs_tuse_o = 2'd1;
                rt_tuse_o = 2'd2;
            end
            is_beq: begin
                rs_tuse_o = 2'd0;
                rt_tuse_o = 2'd0;
            end
            is_jr: begin
                rs_tuse_o = 2'd0;
            end
            is_jal: begin
                wr = 1'b1;
                wa = RA_REG;
            end
            default: begin
            end
        endcase
    end

    // $0 is never a real producer, so it must never cause a stall
    assign wa_o = wa;
    assign we_o = wr && (wa != 5'd0);

endmodule

// File: rtl/hazard_info_pipe.sv
// hazard_info_pipe: decodes D-stage hazard info and carries it through E/M/W,
// aging Tnew. Ports: clk/reset, instr_1/valid_1/stall in; D comb + E/M/W regs out.
module hazard_info_pipe
    import hazard_info_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_1,
    input  logic        valid_1,
    input  logic        stall,
    output logic [4:0]  rs_1,
    output logic [4:0]  rt_1,
    output logic [1:0]  rsTuse,
    output logic [1:0]  rtTuse,
    output logic [4:0]  rs_2,
    output logic [4:0]  rt_2,
    output logic [4:0]  rt_3,
    output logic [4:0]  regWA_2,
    output logic [4:0]  regWA_3,
    output logic [4:0]  regWA_4,
    output logic        RegWrite_2,
    output logic        RegWrite_3,
    output logic        RegWrite_4,
    output logic [1:0]  Tnew_2,
    output logic [1:0]  Tnew_3,
    output logic [1:0]  Tnew_4
);

    logic [4:0]  dec_wa;
    logic        dec_we;
    logic [1:0]  dec_tnew;
    stage_info_t d_info;
    stage_info_t e_d;
    stage_info_t e_q;
    stage_info_t m_d;
    stage_info_t m_q;
    stage_info_t w_d;
    stage_info_t w_q;
    logic        unused_fields;

    assign rs_1 = instr_1[25:21];
    assign rt_1 = instr_1[20:16];

    hazard_info_decode u_decode (
        .instr_i   (instr_1),
        .valid_i   (valid_1),
        .wa_o      (dec_wa),
        .we_o      (dec_we),
        .tnew_o    (dec_tnew),
        .rs_tuse_o (rsTuse),
        .rt_tuse_o (rtTuse)
    );

    // A D-stage bubble carries no source fields either
    always_comb begin
        d_info      = '0;
        d_info.wa   = dec_wa;
        d_info.we   = dec_we;
        d_info.tnew = dec_tnew;
        if (valid_1) begin
            d_info.rs = rs_1;
            d_info.rt = rt_1;
        end
    end

    always_comb begin
        e_d = stall ? '0 : d_info;
        m_d = e_q;
        m_d.tnew = tnew_age(e_q.tnew);
        w_d = m_q;
        w_d.tnew = tnew_age(m_q.tnew);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign rs_2       = e_q.rs;
    assign rt_2       = e_q.rt;
    assign rt_3       = m_q.rt;
    assign regWA_2    = e_q.wa;
    assign regWA_3    = m_q.wa;
    assign regWA_4    = w_q.wa;
    assign RegWrite_2 = e_q.we;
    assign RegWrite_3 = m_q.we;
    assign RegWrite_4 = w_q.we;
    assign Tnew_2     = e_q.tnew;
    assign Tnew_3     = m_q.tnew;
    assign Tnew_4     = w_q.tnew;

    assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt};

endmodule
